// File: rtl/conv2d_pkg.sv
// Shared types and defaults for the Conv2d kernel loader and convolution engine.
package conv2d_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int K_DEF      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } kbl_state_t;

  function automatic int kk(input int k);
    return k * k;
  endfunction

endpackage

// File: rtl/kernel_bank_mem.sv
// Kernel storage: NUM_KERNELS x KK words, one write port, one full-kernel-wide read.
module kernel_bank_mem
  import conv2d_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int K           = K_DEF,
  parameter int NUM_KERNELS = 4,
  localparam int KK         = kk(K),
  localparam int SEL_W      = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
  localparam int WORD_W     = (KK > 1) ? $clog2(KK) : 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [SEL_W-1:0]     wr_kernel,
  input  logic [WORD_W-1:0]    wr_word,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [SEL_W-1:0]     rd_kernel,
  output logic [KK*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [NUM_KERNELS][KK];

  always_ff @(posedge clk) begin
    if (we) mem[wr_kernel][wr_word] <= wr_data;
  end

  // rd_kernel is kept in range by the caller
  always_comb begin
    rd_data = '0;
    for (int w = 0; w < KK; w++) rd_data[w*DATA_W +: DATA_W] = mem[rd_kernel][w];
  end

endmodule

// File: rtl/kernel_bank_loader.sv
// Streams NUM_KERNELS kernels of KxK words into local storage and presents one selected kernel.
// Define KERNEL_DBUF_EN for active/shadow double buffering with a swap on load completion.
//
// state | meaning
// IDLE  | waiting for load_start after reset
// LOAD  | accepting stream words into storage
// DONE  | all kernels stored, load_kernel_done high
module kernel_bank_loader
  import conv2d_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int K           = K_DEF,
  parameter int NUM_KERNELS = 4,
  localparam int KK         = kk(K),
  localparam int SEL_W      = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic [DATA_W-1:0]    kernel_in,
  input  logic                 kernel_valid,
  output logic                 kernel_ready,
  input  logic [SEL_W-1:0]     kernel_sel,
  output logic [KK*DATA_W-1:0] k_out,
  output logic                 sel_err,
  output logic                 load_kernel_done
);

  localparam int WORD_W = (KK > 1) ? $clog2(KK) : 1;

  kbl_state_t        state, state_nxt;
  logic [WORD_W-1:0] word_cnt, word_nxt;
  logic [SEL_W-1:0]  kern_cnt, kern_nxt;
  logic              accept, last_word, sel_oor;
  logic [SEL_W-1:0]  rd_kernel;
  logic [KK*DATA_W-1:0] rd_data;

  assign kernel_ready     = (state == LOAD);
  assign load_kernel_done = (state == DONE);

  // a restart pulse drops any word offered in the same cycle
  assign accept    = kernel_valid && kernel_ready && !load_start;
  assign last_word = accept && (word_cnt == WORD_W'(KK - 1))
                            && (kern_cnt == SEL_W'(NUM_KERNELS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      word_cnt <= '0;
      kern_cnt <= '0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_nxt;
      kern_cnt <= kern_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = word_cnt;
    kern_nxt  = kern_cnt;
    if (load_start) begin
      state_nxt = LOAD;
      word_nxt  = '0;
      kern_nxt  = '0;
    end else begin
      case (state)
        IDLE: ;
        LOAD: begin
          if (accept) begin
            if (word_cnt == WORD_W'(KK - 1)) begin
              word_nxt = '0;
              kern_nxt = kern_cnt + SEL_W'(1);
              if (last_word) begin
                kern_nxt  = '0;
                state_nxt = DONE;
              end
            end else begin
              word_nxt = word_cnt + WORD_W'(1);
            end
          end
        end
        DONE: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign sel_oor   = 32'(kernel_sel) >= NUM_KERNELS;
  assign rd_kernel = sel_oor ? '0 : kernel_sel;

`ifdef KERNEL_DBUF_EN
  logic                 active;
  logic [KK*DATA_W-1:0] rd_bank0, rd_bank1;

  // swap only on a completed load; restarts and resets never reach last_word
  always_ff @(posedge clk) begin
    if (reset)          active <= 1'b0;
    else if (last_word) active <= ~active;
  end

  kernel_bank_mem #(.DATA_W(DATA_W), .K(K), .NUM_KERNELS(NUM_KERNELS)) u_bank0 (
    .clk       (clk),
    .we        (accept && active),
    .wr_kernel (kern_cnt),
    .wr_word   (word_cnt),
    .wr_data   (kernel_in),
    .rd_kernel (rd_kernel),
    .rd_data   (rd_bank0)
  );

  kernel_bank_mem #(.DATA_W(DATA_W), .K(K), .NUM_KERNELS(NUM_KERNELS)) u_bank1 (
    .clk       (clk),
    .we        (accept && !active),
    .wr_kernel (kern_cnt),
    .wr_word   (word_cnt),
    .wr_data   (kernel_in),
    .rd_kernel (rd_kernel),
    .rd_data   (rd_bank1)
  );

  assign rd_data = active ? rd_bank1 : rd_bank0;
`else
  kernel_bank_mem #(.DATA_W(DATA_W), .K(K), .NUM_KERNELS(NUM_KERNELS)) u_bank0 (
    .clk       (clk),
    .we        (accept),
    .wr_kernel (kern_cnt),
    .wr_word   (word_cnt),
    .wr_data   (kernel_in),
    .rd_kernel (rd_kernel),
    .rd_data   (rd_data)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      k_out   <= '0;
      sel_err <= 1'b0;
    end else begin
      k_out   <= sel_oor ? '0 : rd_data;
      sel_err <= sel_oor;
    end
  end

endmodule
